usb_boot_supervisor: RTL and testbench
======================================

// Module: usb_boot_supervisor
// PURPOSE
//  Parametrised bootloader housekeeping block: status-LED driver, USB host-presence watchdog and boot sequencer.
//  Sits beside usb_fs_pe; consumes sof_valid from the protocol engine and boot requests from the SPI bridge endpoint.
//  Drives the LEDs and the single boot strobe to the FPGA warm-boot primitive.
//  Adds over the previous generation: exact ms timebase, N LED channels with per-channel mode, watchdog enable,
//  and an abortable boot-delay state.
// PARAMETERS
//  CLK_FREQ_HZ    48000000  clk frequency; ms tick period = CLK_FREQ_HZ/1000 cycles (must divide exactly)
//  PWM_BITS       8         PWM / breathe level resolution
//  NUM_LEDS       1         number of LED channels (1..8)
//  BLINK_MS       250       blink half-period in ms
//  SOF_TIMEOUT_MS 4000      ms without SOF before host_timeout (>=1)
//  BOOT_DELAY_MS  10        ms between boot decision and boot assertion (>=1)
// PORTS
//  clk          in   1           system clock, all logic rising-edge
//  reset        in   1           synchronous, active-high
//  led_mode     in   2*NUM_LEDS  per channel [2i+1:2i]: 0 off, 1 on, 2 breathe, 3 blink
//  led          out  NUM_LEDS    registered LED drive
//  sof_valid    in   1           1-cycle pulse per received SOF
//  host_wd_en   in   1           1 = host-presence watchdog enabled
//  boot_req     in   1           1-cycle pulse, boot to user design requested by bridge endpoint
//  host_timeout out  1           no SOF for SOF_TIMEOUT_MS (level)
//  boot_pending out  1           FSM in ARMED
//  boot         out  1           sticky boot strobe to warm-boot primitive
// BEHAVIOUR
//  Reset: all counters 0, breathe dir up, FSM IDLE; led, host_timeout, boot_pending, boot all 0 on next edge.
//  ms_tick: divider counts 0..CLK_FREQ_HZ/1000-1; 1-cycle pulse on terminal count, then wraps to 0.
//  pwm_cnt: free-running PWM_BITS counter, wraps 2^PWM_BITS-1 -> 0.
//  Breathe level (shared): on ms_tick, up: level==max ? dir<=down (level held) : level+1.
//   Down: level==0 ? dir<=up : level-1. Period = 2*2^PWM_BITS ms.
//  Blink phase: toggles every BLINK_MS ms ticks, starts 0.
//  led[i] registered (1 cycle after inputs): off->0, on->1, breathe->(level > pwm_cnt), blink->phase.
//   Level 0 gives a dark LED; level max gives 1 on all counts but pwm_cnt==max.
//  Watchdog: ms counter increments on ms_tick and saturates at SOF_TIMEOUT_MS; host_timeout = (cnt==SOF_TIMEOUT_MS), registered.
//   sof_valid clears cnt and host_timeout next cycle; sof_valid beats ms_tick and threshold in the same cycle.
//   host_wd_en=0 holds cnt at 0 and host_timeout at 0.
//  Boot FSM (dly = ms counter, abortable flag):
//   IDLE  : boot_req -> ARMED, abortable=0. Else host_timeout -> ARMED, abortable=1. dly<=0.
//   ARMED : boot_pending=1. On ms_tick dly+1; dly reaching BOOT_DELAY_MS -> BOOT.
//           abortable && !host_timeout -> IDLE (SOF returned).
//           boot_req clears abortable; boot_req wins over abort in the same cycle.
//   BOOT  : boot=1, boot_pending=0; terminal, leaves only on reset. Further inputs ignored.
//  Reset mid-ARMED or in BOOT returns to IDLE with boot=0 next cycle.
// TESTING (bench: CLK_FREQ_HZ=4000 -> 4 cycles/ms, PWM_BITS=3, BLINK_MS=2, SOF_TIMEOUT_MS=5, BOOT_DELAY_MS=3)
//  Ramp: mode=2, no SOF, wd off -> level 0..7, holds 7 one tick, falls to 0; led high (level) of 8 pwm counts; period 16 ms.
//  Modes: NUM_LEDS=2, led_mode=4'b1101 -> led[0]=1 constant, led[1] toggles every 8 cycles.
//  Watchdog: wd_en=1, no SOF -> host_timeout rises 20 cycles after reset. SOF pulse -> 0 next cycle.
//   SOF on the threshold cycle -> host_timeout stays 0.
//  Timeout boot: timeout persists -> boot_pending 1, boot=1 after 3 ms ticks. SOF after 1 ms in ARMED -> IDLE, boot stays 0.
//  Bridge boot: boot_req pulse -> ARMED; SOF pulses during ARMED do not abort; boot=1 after 3 ms, stays 1 through more boot_req/SOF.
//  Reset: assert reset during ARMED and in BOOT -> boot, boot_pending, led all 0 next cycle; FSM IDLE.

Source files
------------

// File: rtl/usb_boot_supervisor_if.sv
// ============================================================================
//  Module      : usb_boot_supervisor_if
//  Description : Signal bundle between the boot supervisor and its neighbours
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usb_boot_supervisor_if #(
    parameter int NUM_LEDS = 1
);
    logic [2*NUM_LEDS-1:0] led_mode;
    logic [NUM_LEDS-1:0]   led;
    logic                  sof_valid;
    logic                  host_wd_en;
    logic                  boot_req;
    logic                  host_timeout;
    logic                  boot_pending;
    logic                  boot;

    modport master (
        output led_mode, sof_valid, host_wd_en, boot_req,
        input  led, host_timeout, boot_pending, boot
    );

    modport slave (
        input  led_mode, sof_valid, host_wd_en, boot_req,
        output led, host_timeout, boot_pending, boot
    );
endinterface

`default_nettype wire

// File: rtl/usb_boot_supervisor.sv
// ============================================================================
//  Module      : usb_boot_supervisor
//  Description : Status LEDs, USB host-presence watchdog and warm-boot sequencer
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_boot_supervisor #(
    parameter int CLK_FREQ_HZ    = 48000000,
    parameter int PWM_BITS       = 8,
    parameter int NUM_LEDS       = 1,
    parameter int BLINK_MS       = 250,
    parameter int SOF_TIMEOUT_MS = 4000,
    parameter int BOOT_DELAY_MS  = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    usb_boot_supervisor_if.slave bus
);

    localparam int DIV   = CLK_FREQ_HZ / 1000;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BL_W  = $clog2(BLINK_MS + 1);
    localparam int WD_W  = $clog2(SOF_TIMEOUT_MS + 1);
    localparam int DLY_W = $clog2(BOOT_DELAY_MS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [BL_W-1:0]  BL_LAST   = BL_W'(BLINK_MS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(SOF_TIMEOUT_MS);
    localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(BOOT_DELAY_MS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_BOOT  = 2'd2;

    logic [DIV_W-1:0]    div_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] level_q;
    logic                dir_down_q;
    logic [BL_W-1:0]     blink_cnt_q;
    logic                phase_q;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                host_timeout_q;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [1:0]          state_q, state_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic                abort_q, abort_d;
    logic                w_ms_tick;
    logic                w_breathe_on;
    logic                w_boot_pending;
    logic                w_boot;

    assign w_ms_tick    = (div_q == DIV_LAST);
    assign w_breathe_on = (level_q > pwm_q);

    // Timebase, PWM, triangle breathe level and blink phase
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            pwm_q       <= '0;
            level_q     <= '0;
            dir_down_q  <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            div_q <= w_ms_tick ? '0 : div_q + DIV_W'(1);
            pwm_q <= pwm_q + PWM_BITS'(1);
            if (w_ms_tick) begin
                if (!dir_down_q) begin
                    if (level_q == '1) dir_down_q <= 1'b1;
                    else               level_q    <= level_q + PWM_BITS'(1);
                end else begin
                    if (level_q == '0) dir_down_q <= 1'b0;
                    else               level_q    <= level_q - PWM_BITS'(1);
                end
                if (blink_cnt_q == BL_LAST) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BL_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        assign led_d[i] = (bus.led_mode[2*i +: 2] == 2'd0) ? 1'b0 :
                          (bus.led_mode[2*i +: 2] == 2'd1) ? 1'b1 :
                          (bus.led_mode[2*i +: 2] == 2'd2) ? w_breathe_on :
                                                             phase_q;
    end

    // SOF has priority over both the ms increment and the threshold compare
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (!bus.host_wd_en || bus.sof_valid)
            wd_cnt_d = '0;
        else if (w_ms_tick && (wd_cnt_q != WD_LIMIT))
            wd_cnt_d = wd_cnt_q + WD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q       <= '0;
            host_timeout_q <= 1'b0;
            led_q          <= '0;
        end else begin
            wd_cnt_q       <= wd_cnt_d;
            host_timeout_q <= (wd_cnt_d == WD_LIMIT);
            led_q          <= led_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            abort_q <= abort_d;
        end
    end

    // A bridge request makes the pending boot unconditional
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                dly_d = '0;
                if (bus.boot_req) begin
                    state_d = S_ARMED;
                    abort_d = 1'b0;
                end else if (host_timeout_q) begin
                    state_d = S_ARMED;
                    abort_d = 1'b1;
                end
            end
            S_ARMED: begin
                if (w_ms_tick)    dly_d   = dly_q + DLY_W'(1);
                if (bus.boot_req) abort_d = 1'b0;
                if (w_ms_tick && (dly_q == DLY_LAST))
                    state_d = S_BOOT;
                else if (abort_q && !host_timeout_q && !bus.boot_req)
                    state_d = S_IDLE;
            end
            S_BOOT:  state_d = S_BOOT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_boot_pending = 1'b0;
        w_boot         = 1'b0;
        case (state_q)
            S_ARMED: w_boot_pending = 1'b1;
            S_BOOT:  w_boot         = 1'b1;
            default: ;
        endcase
    end

    assign bus.led          = led_q;
    assign bus.host_timeout = host_timeout_q;
    assign bus.boot_pending = w_boot_pending;
    assign bus.boot         = w_boot;

endmodule

`default_nettype wire

// File: tb/tb_usb_boot_supervisor.sv
// ============================================================================
//  Module      : tb_usb_boot_supervisor
//  Description : Directed scoreboard bench for usb_boot_supervisor
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_boot_supervisor;

    localparam int K_LED  = 0;
    localparam int K_HT   = 1;
    localparam int K_PEND = 2;
    localparam int K_BOOT = 3;

    typedef struct {
        string      tag;
        int         kind;
        logic [7:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n      = 0;
    exp_t sbq[$];

    usb_boot_supervisor_if #(.NUM_LEDS(2)) bus ();

    usb_boot_supervisor #(
        .CLK_FREQ_HZ   (4000),
        .PWM_BITS      (3),
        .NUM_LEDS      (2),
        .BLINK_MS      (2),
        .SOF_TIMEOUT_MS(5),
        .BOOT_DELAY_MS (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    function automatic logic [7:0] observe(input int kind);
        case (kind)
            K_LED:   return {6'b0, bus.led};
            K_HT:    return {7'b0, bus.host_timeout};
            K_PEND:  return {7'b0, bus.boot_pending};
            default: return {7'b0, bus.boot};
        endcase
    endfunction

    // Expected led after edge t in breathe mode, from the closed-form ramp
    function automatic logic exp_breathe(input int t);
        int p;
        int m;
        int lvl;
        p   = t - 1;
        m   = (p / 4) % 16;
        lvl = (m <= 7) ? m : 15 - m;
        return lvl > (p % 8);
    endfunction

    task automatic push(input string tag, input int kind, input logic [7:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic check_now();
        exp_t       e;
        logic [7:0] o;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = observe(e.kind);
            checks++;
            assert (o === e.exp)
            else begin
                errors++;
                $error("FAIL %s @n=%0d observed=%0h expected=%0h", e.tag, n, o, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        check_now();
    endtask

    task automatic adv(input int t);
        while (n < t - 1) step();
    endtask

    task automatic do_reset(input logic [3:0] mode, input logic wd);
        reset          = 1'b1;
        bus.led_mode   = mode;
        bus.host_wd_en = wd;
        bus.boot_req   = 1'b0;
        bus.sof_valid  = 1'b0;
        @(posedge clk);
        #1;
        n     = 0;
        reset = 1'b0;
    endtask

    task automatic push_reset_state(input string tag);
        push(tag, K_LED,  8'h00);
        push(tag, K_HT,   8'h00);
        push(tag, K_PEND, 8'h00);
        push(tag, K_BOOT, 8'h00);
    endtask

    initial begin
        reset          = 1'b1;
        bus.led_mode   = '0;
        bus.host_wd_en = 1'b0;
        bus.boot_req   = 1'b0;
        bus.sof_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state and breathe ramp on both channels
        do_reset(4'b1010, 1'b0);
        push_reset_state("reset_init");
        check_now();
        for (int t = 1; t <= 80; t++) begin
            adv(t);
            push("ramp", K_LED, {6'b0, {2{exp_breathe(t)}}});
            step();
        end

        // Channel 0 on, channel 1 blink
        do_reset(4'b1101, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            adv(t);
            push("modes", K_LED, {6'b0, 1'(((t - 1) / 8) % 2), 1'b1});
            step();
        end

        // Watchdog timeout leading to boot
        do_reset(4'b0000, 1'b1);
        adv(19); push("wd_pre", K_HT, 8'h00); step();
        push("wd_rise", K_HT, 8'h01); push("arm_pre", K_PEND, 8'h00); step();
        push("arm", K_PEND, 8'h01); step();
        adv(31); push("tboot_pre", K_BOOT, 8'h00); push("tboot_pend", K_PEND, 8'h01); step();
        push("tboot", K_BOOT, 8'h01); push("tboot_npend", K_PEND, 8'h00);
        push("tboot_ht", K_HT, 8'h01); step();
        adv(34);
        bus.sof_valid = 1'b1;
        push("sof_clr", K_HT, 8'h00); push("boot_sticky", K_BOOT, 8'h01); step();
        bus.sof_valid = 1'b0;

        // SOF exactly on the threshold cycle
        do_reset(4'b0000, 1'b1);
        adv(20);
        bus.sof_valid = 1'b1;
        push("thr_sof", K_HT, 8'h00); step();
        bus.sof_valid = 1'b0;
        push("thr_idle", K_PEND, 8'h00); step();
        adv(40); push("thr_rearm", K_HT, 8'h01); step();

        // Host returns during abortable delay
        do_reset(4'b0000, 1'b1);
        adv(21); push("ab_arm", K_PEND, 8'h01); step();
        adv(25);
        bus.sof_valid = 1'b1;
        push("ab_ht", K_HT, 8'h00); push("ab_still", K_PEND, 8'h01); step();
        bus.sof_valid = 1'b0;
        push("ab_idle", K_PEND, 8'h00); step();
        adv(36); push("ab_noboot", K_BOOT, 8'h00); push("ab_npend", K_PEND, 8'h00); step();

        // Bridge-requested boot ignores SOF and later requests
        do_reset(4'b0101, 1'b0);
        adv(2);
        bus.boot_req = 1'b1;
        push("br_arm", K_PEND, 8'h01); push("br_led", K_LED, 8'h03); step();
        bus.boot_req = 1'b0;
        adv(6);
        bus.sof_valid = 1'b1;
        push("br_sof", K_PEND, 8'h01); step();
        bus.sof_valid = 1'b0;
        adv(11); push("br_pre", K_BOOT, 8'h00); push("br_pend", K_PEND, 8'h01); step();
        push("br_boot", K_BOOT, 8'h01); push("br_npend", K_PEND, 8'h00); step();
        adv(15);
        bus.boot_req  = 1'b1;
        bus.sof_valid = 1'b1;
        step();
        bus.boot_req  = 1'b0;
        bus.sof_valid = 1'b0;
        adv(20); push("br_hold", K_BOOT, 8'h01); push("br_hold_p", K_PEND, 8'h00); step();

        // Reset while in BOOT
        do_reset(4'b0101, 1'b0);
        push_reset_state("rst_boot");
        check_now();

        // Reset while ARMED
        adv(2);
        bus.boot_req = 1'b1;
        step();
        bus.boot_req = 1'b0;
        adv(5); push("ra_arm", K_PEND, 8'h01); push("ra_led", K_LED, 8'h03); step();
        do_reset(4'b0101, 1'b0);
        push_reset_state("rst_armed");
        check_now();
        adv(14); push("ra_idle", K_PEND, 8'h00); push("ra_noboot", K_BOOT, 8'h00); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
